// File: rtl/uart_pkg.sv
// Shared UART definitions: controller state encoding and baud-rate codes.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_RUN    = 3'd1,
        ST_DRAIN  = 3'd2,
        ST_SWITCH = 3'd3,
        ST_SETTLE = 3'd4
    } baud_ctrl_state_t;

    localparam logic [1:0] BAUD_9600  = 2'b00;
    localparam logic [1:0] BAUD_19200 = 2'b01;
    localparam logic [1:0] BAUD_38400 = 2'b10;
    localparam logic [1:0] BAUD_57600 = 2'b11;

endpackage

// File: rtl/baud_sel_ctrl_if.sv
// Bundle between the UART config/clients, baud_sel_ctrl and baud_sel_gen.
// tick_err exists only when BAUD_WDOG_EN is defined.
interface baud_sel_ctrl_if;

    logic       cfg_valid;
    logic [1:0] cfg_sel;
    logic       cfg_ready;
    logic       tx_req;
    logic       rx_req;
    logic       tx_gnt;
    logic       rx_gnt;
    logic       baud;
    logic       enable_baud;
    logic [1:0] baud_sel;
`ifdef BAUD_WDOG_EN
    logic       tick_err;

    modport master (
        output cfg_valid, cfg_sel, tx_req, rx_req, baud,
        input  cfg_ready, tx_gnt, rx_gnt, enable_baud, baud_sel, tick_err
    );
    modport slave (
        input  cfg_valid, cfg_sel, tx_req, rx_req, baud,
        output cfg_ready, tx_gnt, rx_gnt, enable_baud, baud_sel, tick_err
    );
`else
    modport master (
        output cfg_valid, cfg_sel, tx_req, rx_req, baud,
        input  cfg_ready, tx_gnt, rx_gnt, enable_baud, baud_sel
    );
    modport slave (
        input  cfg_valid, cfg_sel, tx_req, rx_req, baud,
        output cfg_ready, tx_gnt, rx_gnt, enable_baud, baud_sel
    );
`endif

endinterface

// File: rtl/baud_tick_wdog.sv
// Flags a missing baud tick: counts enabled cycles since the last rising
// edge of baud and sets a sticky error when the count hits TICK_TIMEOUT.
module baud_tick_wdog #(
    parameter int TICK_TIMEOUT = 65536
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic baud,
    output logic tick_err
);

    localparam int W = $clog2(TICK_TIMEOUT + 1);
    localparam logic [W-1:0] LIMIT = W'(TICK_TIMEOUT);

    logic         baud_d;
    logic         rise;
    logic [W-1:0] cnt;

    assign rise = baud & ~baud_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            baud_d   <= 1'b0;
            cnt      <= '0;
            tick_err <= 1'b0;
        end else begin
            baud_d <= baud;
            if (!en || rise)
                cnt <= '0;
            else if (cnt != LIMIT)
                cnt <= cnt + 1'b1;
            if (cnt == LIMIT)
                tick_err <= 1'b1;
        end
    end

endmodule

// File: rtl/baud_sel_ctrl.sv
// Owns the shared baud generator: grants ticks to TX/RX and applies rate
// changes only when both are idle. BAUD_WDOG_EN adds the tick watchdog.
module baud_sel_ctrl #(
    parameter int SETTLE_CYCLES = 4,
    parameter int TICK_TIMEOUT  = 65536
) (
    input logic           clk,
    input logic           rst,
    baud_sel_ctrl_if.slave bus
);
    import uart_pkg::*;

    localparam int CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CW-1:0] SETTLE_LOAD = CW'(SETTLE_CYCLES - 1);

    if (SETTLE_CYCLES < 1 || TICK_TIMEOUT < 1) begin : g_bad_cfg
        $error("baud_sel_ctrl: SETTLE_CYCLES and TICK_TIMEOUT must be >= 1");
    end

    baud_ctrl_state_t state;
    baud_ctrl_state_t state_nxt;
    logic             tx_gnt;
    logic             rx_gnt;
    logic             tx_nxt;
    logic             rx_nxt;
    logic [1:0]       sel;
    logic [CW-1:0]    cnt;
    logic             busy;

    assign busy = bus.tx_req | bus.rx_req | tx_gnt | rx_gnt;

    always_comb begin
        state_nxt = state;
        tx_nxt    = 1'b0;
        rx_nxt    = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (bus.cfg_valid)
                    state_nxt = ST_SWITCH;
                else if (bus.tx_req || bus.rx_req)
                    state_nxt = ST_RUN;
            end
            ST_RUN: begin
                tx_nxt = bus.tx_req;
                rx_nxt = bus.rx_req;
                if (bus.cfg_valid)
                    state_nxt = ST_DRAIN;
                else if (!busy)
                    state_nxt = ST_IDLE;
            end
            // Existing grants may only fall here; no new grant is issued.
            ST_DRAIN: begin
                tx_nxt = tx_gnt & bus.tx_req;
                rx_nxt = rx_gnt & bus.rx_req;
                if (!bus.cfg_valid)
                    state_nxt = ST_RUN;
                else if (!tx_gnt && !rx_gnt)
                    state_nxt = ST_SWITCH;
            end
            ST_SWITCH: begin
                state_nxt = bus.cfg_valid ? ST_SETTLE : ST_IDLE;
            end
            ST_SETTLE: begin
                if (cnt == '0)
                    state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= ST_IDLE;
            tx_gnt <= 1'b0;
            rx_gnt <= 1'b0;
            sel    <= BAUD_9600;
            cnt    <= '0;
        end else begin
            state  <= state_nxt;
            tx_gnt <= tx_nxt;
            rx_gnt <= rx_nxt;
            if (state == ST_SWITCH && bus.cfg_valid) begin
                sel <= bus.cfg_sel;
                cnt <= SETTLE_LOAD;
            end else if (state == ST_SETTLE && cnt != '0) begin
                cnt <= cnt - 1'b1;
            end
        end
    end

    assign bus.enable_baud = (state == ST_RUN) || (state == ST_DRAIN);
    assign bus.cfg_ready   = (state == ST_SWITCH);
    assign bus.tx_gnt      = tx_gnt;
    assign bus.rx_gnt      = rx_gnt;
    assign bus.baud_sel    = sel;

`ifdef BAUD_WDOG_EN
    baud_tick_wdog #(
        .TICK_TIMEOUT(TICK_TIMEOUT)
    ) u_wdog (
        .clk     (clk),
        .rst     (rst),
        .en      (bus.enable_baud),
        .baud    (bus.baud),
        .tick_err(bus.tick_err)
    );
`else
    logic unused_baud;
    assign unused_baud = bus.baud;
`endif

endmodule
